sfx_sequencer: RTL

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

---
 rtl/sfx_pkg.sv | 25 ++
 rtl/sfx_sequencer_if.sv | 28 ++
 rtl/sfx_tone_gen.sv | 65 ++++++
 rtl/sfx_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared constants, clip table and FSM state type for the sound-effect sequencer.
package sfx_pkg;

    localparam int unsigned ROM_W     = 19;
    localparam int unsigned NUM_CLIPS = 4;

    localparam int unsigned CLIP_BASE [NUM_CLIPS] = '{0, 16, 32, 48};

    localparam logic [ROM_W-1:0] END_MARK  = 19'h00000;
    localparam logic [ROM_W-1:0] REST_MARK = 19'h7FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Requesters beyond the table fall back to address 0.
    function automatic int unsigned clip_base(input int unsigned idx);
        return (idx < NUM_CLIPS) ? CLIP_BASE[idx[1:0]] : 0;
    endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Request/ROM/codec signal bundle between the sequencer and its surroundings.
interface sfx_sequencer_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10
);
    import sfx_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  rom_addr;
    logic [ROM_W-1:0]   rom_q;
    logic               audio_out_allowed;
    logic signed [31:0] sample;
    logic               write_audio_out;

    modport master (
        output req, rom_q, audio_out_allowed,
        input  grant, busy, done, rom_addr, sample, write_audio_out
    );

    modport slave (
        input  req, rom_q, audio_out_allowed,
        output grant, busy, done, rom_addr, sample, write_audio_out
    );

endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: half-period counter, snd toggle and registered sample.
module sfx_tone_gen
    import sfx_pkg::*;
#(
    parameter int unsigned AMPL = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               run_i,
    input  logic               clr_i,
    input  logic               busy_i,
    input  logic [ROM_W-1:0]   delay_i,
    output logic signed [31:0] sample_o
);

    localparam logic signed [31:0] AMP_P = $signed(32'(AMPL));
    localparam logic signed [31:0] AMP_N = -AMP_P;

    logic [ROM_W-1:0]   delay_q, delay_d;
    logic [ROM_W-1:0]   cnt_q, cnt_d;
    logic               snd_q, snd_d;
    logic signed [31:0] sample_q, sample_d;

    // Sample follows the post-edge snd so it lines up with the note timing.
    always_comb begin
        delay_d  = delay_q;
        cnt_d    = cnt_q;
        snd_d    = snd_q;
        sample_d = 32'sd0;
        if (load_i) begin
            delay_d = delay_i;
            cnt_d   = '0;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == delay_q) begin
                cnt_d = '0;
                snd_d = ~snd_q;
            end else begin
                cnt_d = cnt_q + ROM_W'(1);
            end
        end
        if (busy_i && (delay_d != REST_MARK)) begin
            sample_d = snd_d ? AMP_P : AMP_N;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q  <= '0;
            cnt_q    <= '0;
            snd_q    <= 1'b0;
            sample_q <= 32'sd0;
        end else begin
            delay_q  <= delay_d;
            cnt_q    <= cnt_d;
            snd_q    <= snd_d;
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: priority arbiter, clip FSM and beat counter driving a tone generator.
// Define SFX_PREEMPT_EN to let a higher-priority request abort the clip being played.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BEAT_CYCLES = 2500000,
    parameter int unsigned AMPL        = 100000000
) (
    input logic            CLOCK_50,
    input logic            reset,
    sfx_sequencer_if.slave sfx_if
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_q;
    logic               win_valid_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               start_c, preempt_c, beat_end_c, load_c, run_c;
    logic signed [31:0] sample_w;

    // Fixed priority: the lowest set request index wins.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (sfx_if.req[i]) begin
                win_valid_c = 1'b1;
                win_idx_c   = IDX_W'(i);
            end
        end
    end

`ifdef SFX_PREEMPT_EN
    logic [IDX_W-1:0] act_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            act_q <= '0;
        end else if (start_c || preempt_c) begin
            act_q <= win_idx_c;
        end
    end

    assign preempt_c = (state_q == PLAY) && win_valid_c && (win_idx_c < act_q);
`else
    assign preempt_c = 1'b0;
`endif

    assign start_c    = (state_q == IDLE) && win_valid_c;
    assign beat_end_c = (state_q == PLAY) && (beat_q == BEAT_LAST);
    assign load_c     = (state_q == LOAD) && (sfx_if.rom_q != END_MARK);
    assign run_c      = (state_q == PLAY);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_valid_c) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = (sfx_if.rom_q == END_MARK) ? DONE : PLAY;
            PLAY: begin
                if (preempt_c) begin
                    state_d = FETCH;
                end else if (beat_end_c) begin
                    state_d = (addr_q == ADDR_MAX) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they align with it.
    always_comb begin
        grant_d = '0;
        addr_d  = addr_q;
        beat_d  = beat_q;
        if (start_c || preempt_c) begin
            grant_d = NUM_REQ'(1) << win_idx_c;
            addr_d  = ADDR_W'(clip_base(32'(win_idx_c)));
            beat_d  = '0;
        end else if (state_q == LOAD) begin
            beat_d = '0;
        end else if (state_q == PLAY) begin
            if (beat_end_c) begin
                beat_d = '0;
                if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
        busy_d = (state_d == FETCH) || (state_d == LOAD) || (state_d == PLAY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            grant_q <= grant_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= sfx_if.audio_out_allowed;
        end
    end

    sfx_tone_gen #(
        .AMPL(AMPL)
    ) u_tone (
        .clk     (CLOCK_50),
        .rst     (reset),
        .load_i  (load_c),
        .run_i   (run_c),
        .clr_i   (preempt_c),
        .busy_i  (busy_d),
        .delay_i (sfx_if.rom_q),
        .sample_o(sample_w)
    );

    assign sfx_if.grant           = grant_q;
    assign sfx_if.busy            = busy_q;
    assign sfx_if.done            = done_q;
    assign sfx_if.rom_addr        = addr_q;
    assign sfx_if.sample          = sample_w;
    assign sfx_if.write_audio_out = wr_q;

endmodule
